// File: rtl/step_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : step_clock_gen
//  Description : Front-end clock stage for the single-cycle CPU board build.
//                Debounces the raw step and run buttons and generates
//                cpu_clock. In step mode each press gives one pulse. In run
//                mode pulses come from a divider. A PC breakpoint can halt
//                free-run.
//  Ports       : clock, reset_n       - board clock, async active-low reset
//                step_btn, run_btn    - raw active-high buttons (asynchronous)
//                bp_en, bp_addr, pc   - breakpoint enable/address, current PC
//                cpu_clock            - registered CPU clock, idles low
//                running, halted_bp   - mode flags for LEDs
//                step_count           - count of cpu_clock rising edges
//  Revision    : 1.0 - initial release
// ============================================================================
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 5000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int PC_W            = 9
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            step_btn,
  input  logic            run_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_clock,
  output logic            running,
  output logic            halted_bp,
  output logic [7:0]      step_count
);

  localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES);
  localparam int c_div_w = $clog2(RUN_DIV);
  localparam int c_pul_w = $clog2(PULSE_CYCLES + 1);

  localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);
  localparam logic [c_pul_w-1:0] c_pul_last = c_pul_w'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_STEP = 2'd0,
    S_RUN  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = step, bit 1 = run.
  // --------------------------------------------------------------------------
  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {run_btn, step_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_press;
    logic [c_db_w-1:0] r_cnt;

    // The accepted level only moves after the synchronized input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive samples; any sample
    // that agrees again restarts the count. The press pulse is raised on the
    // same edge that accepts a new high level, so it lasts one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        r_press <= 1'b0;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  logic w_step_press;
  logic w_run_press;
  logic w_bp_hit;
  logic w_div_last;
  logic w_pulse_last;

  assign w_step_press = w_press[0];
  assign w_run_press  = w_press[1];
  assign w_bp_hit     = bp_en && (pc == bp_addr);

  // --------------------------------------------------------------------------
  // Mode FSM with registered outputs.
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_div_w-1:0]   r_div;
  logic [c_pul_w-1:0]   r_pulse_cnt;

  assign w_div_last   = (r_div == c_div_last);
  assign w_pulse_last = (r_pulse_cnt == c_pul_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_STEP;
      r_div       <= '0;
      r_pulse_cnt <= '0;
      cpu_clock   <= 1'b0;
      running     <= 1'b0;
      halted_bp   <= 1'b0;
      step_count  <= 8'd0;
    end else begin
      case (r_state)
        S_STEP: begin
          // Run wins over a simultaneous step press.
          if (w_run_press) begin
            running   <= 1'b1;
            halted_bp <= 1'b0;
            r_div     <= '0;
            r_state   <= S_RUN;
          end else if (w_step_press) begin
            halted_bp   <= 1'b0;
            cpu_clock   <= 1'b1;
            step_count  <= step_count + 8'd1;
            r_pulse_cnt <= '0;
            r_state     <= S_HIGH;
          end
        end

        S_RUN: begin
          if (w_run_press) begin
            running <= 1'b0;
            r_state <= S_STEP;
          end else if (w_div_last) begin
            r_div <= '0;
            // The PC is only examined at the divider terminal count; a hit
            // swallows this pulse and drops back to manual mode.
            if (w_bp_hit) begin
              running   <= 1'b0;
              halted_bp <= 1'b1;
              r_state   <= S_STEP;
            end else begin
              cpu_clock   <= 1'b1;
              step_count  <= step_count + 8'd1;
              r_pulse_cnt <= '0;
              r_state     <= S_HIGH;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_HIGH: begin
          if (w_run_press) begin
            running   <= ~running;
            halted_bp <= 1'b0;
          end
          // Keep the divider phase-locked to the previous rising edge while
          // free-running; restart it if run mode is switched on mid-pulse.
          if (w_run_press && !running) begin
            r_div <= '0;
          end else if (running) begin
            r_div <= w_div_last ? '0 : r_div + 1'b1;
          end
          // The pulse always finishes at full width, whatever the buttons do.
          if (w_pulse_last) begin
            cpu_clock   <= 1'b0;
            r_pulse_cnt <= '0;
            r_state     <= (running ^ w_run_press) ? S_RUN : S_STEP;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end

        default: begin
          cpu_clock <= 1'b0;
          r_state   <= S_STEP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_clock_gen
//  Description : Directed self-checking bench for step_clock_gen with
//                DEBOUNCE_CYCLES=4, RUN_DIV=10, PULSE_CYCLES=2. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_clock_gen;

  logic       clock;
  logic       reset_n;
  logic       step_btn;
  logic       run_btn;
  logic       bp_en;
  logic [8:0] bp_addr;
  logic [8:0] pc;
  logic       cpu_clock;
  logic       running;
  logic       halted_bp;
  logic [7:0] step_count;

  int   total;
  int   bad;
  logic prev_clk;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (10),
    .PULSE_CYCLES   (2),
    .PC_W           (9)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .step_btn  (step_btn),
    .run_btn   (run_btn),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_clock (cpu_clock),
    .running   (running),
    .halted_bp (halted_bp),
    .step_count(step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Models the CPU PC: advances by 4 on every cpu_clock rise seen at a
  // falling edge. Releases run_btn after release_at cycles.
  task automatic cyc_pc(input int n, input int release_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i + 1 == release_at) run_btn = 1'b0;
      if (cpu_clock && !prev_clk) pc = pc + 9'd4;
      prev_clk = cpu_clock;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    step_btn = 1'b0;
    run_btn  = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 9'h000;
    pc       = 9'h000;
    prev_clk = 1'b0;

    // ---- 1. reset and bounce rejection ----
    cyc(3);
    chk("rst_cpu_clock",  cpu_clock,  0);
    chk("rst_running",    running,    0);
    chk("rst_halted_bp",  halted_bp,  0);
    chk("rst_step_count", step_count, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      cyc(2);
    end
    step_btn = 1'b0;
    cyc(8);
    chk("bounce_cpu_clock",  cpu_clock,  0);
    chk("bounce_step_count", step_count, 0);

    // ---- 2. single step: rise 7 cycles after raw edge, 2 cycles high ----
    step_btn = 1'b1;
    cyc(6);
    chk("step_before_rise", cpu_clock, 0);
    cyc(1);
    chk("step_rise",       cpu_clock,  1);
    chk("step_count_1",    step_count, 1);
    cyc(1);
    chk("step_high_2",     cpu_clock,  1);
    cyc(1);
    chk("step_fall",       cpu_clock,  0);
    cyc(50);
    chk("step_hold_count", step_count, 1);
    chk("step_hold_low",   cpu_clock,  0);
    step_btn = 1'b0;
    cyc(8);
    chk("step_release_count", step_count, 1);

    // ---- 3. run mode: enter at +7, rises at +17, +27, ... ----
    run_btn = 1'b1;
    cyc(7);
    chk("run_entered",  running,   1);
    chk("run_no_pulse", cpu_clock, 0);
    cyc(9);
    chk("run_before_rise1", cpu_clock, 0);
    cyc(1);
    chk("run_rise1", cpu_clock, 1);
    run_btn = 1'b0;
    cyc(9);
    chk("run_before_rise2", cpu_clock, 0);
    cyc(1);
    chk("run_rise2",        cpu_clock,  1);
    chk("run_count_rise2",  step_count, 3);
    cyc(28);                           // rises at +37 and +47, then press
    run_btn = 1'b1;                    // stop press acts at +62, after rise at +57
    cyc(7);
    chk("run_stopped", running, 0);
    run_btn = 1'b0;
    cyc(20);
    chk("run_stop_count", step_count, 6);
    chk("run_stop_low",   cpu_clock,  0);

    // ---- 4. breakpoint at pc 0x00C ----
    bp_en    = 1'b1;
    bp_addr  = 9'h00C;
    pc       = 9'h000;
    prev_clk = cpu_clock;
    run_btn  = 1'b1;
    cyc_pc(60, 10);
    chk("bp_pc_reached", pc,         9'h00C);
    chk("bp_count",      step_count, 9);
    chk("bp_running",    running,    0);
    chk("bp_halted",     halted_bp,  1);
    step_btn = 1'b1;
    cyc_pc(7, 0);
    chk("bp_step_rise",    cpu_clock,  1);
    chk("bp_step_cleared", halted_bp,  0);
    chk("bp_step_count",   step_count, 10);
    step_btn = 1'b0;
    cyc_pc(10, 0);
    chk("bp_step_pc",      pc,         9'h010);
    chk("bp_step_running", running,    0);
    bp_en = 1'b0;

    // ---- 5a. step_count wraps after 256 pulses ----
    for (int k = 0; k < 246; k++) begin
      step_btn = 1'b1;
      cyc(8);
      step_btn = 1'b0;
      cyc(8);
    end
    chk("wrap_to_zero", step_count, 0);
    for (int k = 0; k < 10; k++) begin
      step_btn = 1'b1;
      cyc(8);
      step_btn = 1'b0;
      cyc(8);
    end
    chk("wrap_full_256", step_count, 10);

    // ---- 5b. simultaneous presses: run wins, no immediate pulse ----
    step_btn = 1'b1;
    run_btn  = 1'b1;
    cyc(7);
    chk("collide_running", running,    1);
    chk("collide_low",     cpu_clock,  0);
    chk("collide_count",   step_count, 10);
    cyc(1);
    chk("collide_low_next", cpu_clock, 0);
    step_btn = 1'b0;
    run_btn  = 1'b0;

    // ---- 5c. step press landing in HIGH is dropped ----
    cyc(3);
    step_btn = 1'b1;                   // press acts at +18, inside HIGH
    cyc(6);
    chk("high_rise",       cpu_clock,  1);
    chk("high_rise_count", step_count, 11);
    cyc(2);
    chk("high_fall", cpu_clock, 0);
    cyc(1);
    step_btn = 1'b0;
    cyc(6);
    chk("high_drop_low",   cpu_clock,  0);
    chk("high_drop_count", step_count, 11);
    cyc(1);
    chk("high_next_rise",  cpu_clock,  1);
    chk("high_next_count", step_count, 12);

    // ---- 6. asynchronous reset in the middle of a pulse ----
    cyc(10);
    chk("mid_pre_high",    cpu_clock,  1);
    chk("mid_pre_running", running,    1);
    chk("mid_pre_count",   step_count, 13);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cpu_clock",  cpu_clock,  0);
    chk("mid_rst_running",    running,    0);
    chk("mid_rst_halted",     halted_bp,  0);
    chk("mid_rst_step_count", step_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(20);
    chk("post_rst_low",   cpu_clock,  0);
    chk("post_rst_count", step_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
